// File: rtl/pattern_streamer_pkg.sv
// Shared types, bar colour table and TDATA packing for the AXI4-Stream test-pattern source.
package pattern_streamer_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [RGB_W-1:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [31:0] pack_tdata(input logic [RGB_W-1:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/pattern_pixel_lut.sv
// Combinational colour select for one pixel from its coordinates, bar index and frame config.
module pattern_pixel_lut
    import pattern_streamer_pkg::*;
#(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int CELL_LOG2 = 5,
    parameter int SQ_SIZE   = 64,
    localparam int XW = $clog2(X_SIZE),
    localparam int YW = $clog2(Y_SIZE)
) (
    input  mode_e            mode,
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [2:0]       bar_idx,
    input  logic [RGB_W-1:0] fg_rgb,
    input  logic [RGB_W-1:0] bg_rgb,
    input  logic [XW-1:0]    sq_x,
    input  logic [YW-1:0]    sq_y,
    output logic [RGB_W-1:0] rgb
);

    logic cell_x_s;
    logic cell_y_s;
    logic in_sq_s;

    // Cells wider than the frame axis never toggle along it.
    if (CELL_LOG2 < XW) begin : g_cell_x
        assign cell_x_s = x[CELL_LOG2];
    end else begin : g_cell_x0
        assign cell_x_s = 1'b0;
    end

    if (CELL_LOG2 < YW) begin : g_cell_y
        assign cell_y_s = y[CELL_LOG2];
    end else begin : g_cell_y0
        assign cell_y_s = 1'b0;
    end

    // Colour select; the one-bit-wider compares let the square clip instead of wrapping.
    always_comb begin
        in_sq_s = ({1'b0, x} >= {1'b0, sq_x}) &&
                  ({1'b0, x} <  ({1'b0, sq_x} + (XW+1)'(SQ_SIZE))) &&
                  ({1'b0, y} >= {1'b0, sq_y}) &&
                  ({1'b0, y} <  ({1'b0, sq_y} + (YW+1)'(SQ_SIZE)));
        case (mode)
            MODE_SOLID:  rgb = fg_rgb;
            MODE_BARS:   rgb = BAR_RGB[bar_idx];
            MODE_CHECK:  rgb = (cell_x_s ^ cell_y_s) ? fg_rgb : bg_rgb;
            MODE_SQUARE: rgb = in_sq_s ? fg_rgb : bg_rgb;
            default:     rgb = bg_rgb;
        endcase
    end

endmodule

// File: rtl/pattern_streamer.sv
// AXI4-Stream video test-pattern source, one pixel per beat, whole frames only.
// Define PATTERN_ANIMATE_EN to make the mode-3 square bounce around the frame.
module pattern_streamer
    import pattern_streamer_pkg::*;
#(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int CELL_LOG2 = 5,
    parameter int SQ_SIZE   = 64,
    localparam int XW = $clog2(X_SIZE),
    localparam int YW = $clog2(Y_SIZE)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] fg_rgb,
    input  logic [RGB_W-1:0] bg_rgb,
    input  logic [XW-1:0]    sq_x,
    input  logic [YW-1:0]    sq_y,
    output logic [31:0]      out_stream_tdata,
    output logic [3:0]       out_stream_tkeep,
    output logic             out_stream_tlast,
    output logic             out_stream_tuser,
    output logic             out_stream_tvalid,
    input  logic             out_stream_tready,
    output logic [15:0]      frame_count,
    output logic             busy
);

    localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
    localparam logic [XW-1:0] BAR_LAST = XW'(X_SIZE / 8 - 1);

    state_e           state_r;
    logic [XW-1:0]    x_r, nx_s;
    logic [YW-1:0]    y_r, ny_s;
    logic [XW-1:0]    bar_cnt_r, nbar_cnt_s;
    logic [2:0]       bar_idx_r, nbar_idx_s;
    mode_e            cfg_mode_r, lut_mode_s;
    logic [RGB_W-1:0] cfg_fg_r, cfg_bg_r, lut_fg_s, lut_bg_s, lut_rgb_s;
    logic [XW-1:0]    lut_sq_x_s;
    logic [YW-1:0]    lut_sq_y_s;
    logic [31:0]      tdata_r;
    logic             tlast_r, tuser_r, tvalid_r, busy_r;
    logic [15:0]      frame_count_r;
    logic             fire_s, frame_end_s, start_s, eol_s, load_s;

    // Beat handshake, frame-end detection and next-pixel coordinates.
    always_comb begin
        fire_s      = tvalid_r & out_stream_tready;
        eol_s       = (x_r == X_LAST);
        frame_end_s = (state_r == ST_RUN) && eol_s && (y_r == Y_LAST);
        start_s     = (state_r == ST_IDLE) || frame_end_s;
        load_s      = ((state_r == ST_IDLE) && enable) ||
                      ((state_r == ST_RUN) && fire_s && (!frame_end_s || enable));
        nx_s = (start_s || eol_s) ? {XW{1'b0}} : x_r + XW'(1);
        ny_s = start_s ? {YW{1'b0}} : (eol_s ? y_r + YW'(1) : y_r);
        if (start_s || eol_s) begin
            nbar_cnt_s = {XW{1'b0}};
            nbar_idx_s = 3'd0;
        end else if (bar_cnt_r == BAR_LAST) begin
            nbar_cnt_s = {XW{1'b0}};
            nbar_idx_s = bar_idx_r + 3'd1;
        end else begin
            nbar_cnt_s = bar_cnt_r + XW'(1);
            nbar_idx_s = bar_idx_r;
        end
        lut_mode_s = start_s ? mode_e'(mode) : cfg_mode_r;
        lut_fg_s   = start_s ? fg_rgb : cfg_fg_r;
        lut_bg_s   = start_s ? bg_rgb : cfg_bg_r;
    end

`ifdef PATTERN_ANIMATE_EN
    logic [XW-1:0] anim_x_r, anim_nx_s;
    logic [YW-1:0] anim_y_r, anim_ny_s;
    logic          dir_x_dn_r, dir_y_dn_r, ndir_x_dn_s, ndir_y_dn_s;

    // Next bounce position: an origin at or past an edge snaps onto it and turns around.
    always_comb begin
        if (!dir_x_dn_r) begin
            if (({1'b0, anim_x_r} + (XW+1)'(1) + (XW+1)'(SQ_SIZE)) >= (XW+1)'(X_SIZE)) begin
                anim_nx_s   = XW'(X_SIZE - SQ_SIZE);
                ndir_x_dn_s = 1'b1;
            end else begin
                anim_nx_s   = anim_x_r + XW'(1);
                ndir_x_dn_s = 1'b0;
            end
        end else if (anim_x_r <= XW'(1)) begin
            anim_nx_s   = {XW{1'b0}};
            ndir_x_dn_s = 1'b0;
        end else begin
            anim_nx_s   = anim_x_r - XW'(1);
            ndir_x_dn_s = 1'b1;
        end
        if (!dir_y_dn_r) begin
            if (({1'b0, anim_y_r} + (YW+1)'(1) + (YW+1)'(SQ_SIZE)) >= (YW+1)'(Y_SIZE)) begin
                anim_ny_s   = YW'(Y_SIZE - SQ_SIZE);
                ndir_y_dn_s = 1'b1;
            end else begin
                anim_ny_s   = anim_y_r + YW'(1);
                ndir_y_dn_s = 1'b0;
            end
        end else if (anim_y_r <= YW'(1)) begin
            anim_ny_s   = {YW{1'b0}};
            ndir_y_dn_s = 1'b0;
        end else begin
            anim_ny_s   = anim_y_r - YW'(1);
            ndir_y_dn_s = 1'b1;
        end
        if (state_r == ST_IDLE) begin
            lut_sq_x_s = sq_x;
            lut_sq_y_s = sq_y;
        end else if (frame_end_s) begin
            lut_sq_x_s = anim_nx_s;
            lut_sq_y_s = anim_ny_s;
        end else begin
            lut_sq_x_s = anim_x_r;
            lut_sq_y_s = anim_y_r;
        end
    end

    // Square origin and direction registers, seeded on every run start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            anim_x_r   <= {XW{1'b0}};
            anim_y_r   <= {YW{1'b0}};
            dir_x_dn_r <= 1'b0;
            dir_y_dn_r <= 1'b0;
        end else if (srst) begin
            anim_x_r   <= {XW{1'b0}};
            anim_y_r   <= {YW{1'b0}};
            dir_x_dn_r <= 1'b0;
            dir_y_dn_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && enable) begin
            anim_x_r   <= sq_x;
            anim_y_r   <= sq_y;
            dir_x_dn_r <= 1'b0;
            dir_y_dn_r <= 1'b0;
        end else if (fire_s && frame_end_s) begin
            anim_x_r   <= anim_nx_s;
            anim_y_r   <= anim_ny_s;
            dir_x_dn_r <= ndir_x_dn_s;
            dir_y_dn_r <= ndir_y_dn_s;
        end
    end
`else
    logic [XW-1:0] cfg_sq_x_r;
    logic [YW-1:0] cfg_sq_y_r;

    // Static square: origin comes from the per-frame latched inputs.
    always_comb begin
        lut_sq_x_s = start_s ? sq_x : cfg_sq_x_r;
        lut_sq_y_s = start_s ? sq_y : cfg_sq_y_r;
    end

    // Per-frame square origin latch.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_sq_x_r <= {XW{1'b0}};
            cfg_sq_y_r <= {YW{1'b0}};
        end else if (srst) begin
            cfg_sq_x_r <= {XW{1'b0}};
            cfg_sq_y_r <= {YW{1'b0}};
        end else if (load_s && start_s) begin
            cfg_sq_x_r <= sq_x;
            cfg_sq_y_r <= sq_y;
        end
    end
`endif

    pattern_pixel_lut #(
        .X_SIZE    (X_SIZE),
        .Y_SIZE    (Y_SIZE),
        .CELL_LOG2 (CELL_LOG2),
        .SQ_SIZE   (SQ_SIZE)
    ) u_lut (
        .mode    (lut_mode_s),
        .x       (nx_s),
        .y       (ny_s),
        .bar_idx (nbar_idx_s),
        .fg_rgb  (lut_fg_s),
        .bg_rgb  (lut_bg_s),
        .sq_x    (lut_sq_x_s),
        .sq_y    (lut_sq_y_s),
        .rgb     (lut_rgb_s)
    );

    // Run/idle control, beat valid, busy and completed-frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_IDLE;
            tvalid_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (srst) begin
            state_r       <= ST_IDLE;
            tvalid_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r  <= ST_RUN;
                        tvalid_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        tvalid_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (fire_s && frame_end_s) begin
                        frame_count_r <= frame_count_r + 16'd1;
                        if (!enable) begin
                            state_r  <= ST_IDLE;
                            tvalid_r <= 1'b0;
                            busy_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tvalid_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Output beat register, coordinate counters and per-frame config latch.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            bar_cnt_r  <= {XW{1'b0}};
            bar_idx_r  <= 3'd0;
            cfg_mode_r <= MODE_SOLID;
            cfg_fg_r   <= 24'h000000;
            cfg_bg_r   <= 24'h000000;
            tdata_r    <= 32'h0000_0000;
            tlast_r    <= 1'b0;
            tuser_r    <= 1'b0;
        end else if (srst) begin
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            bar_cnt_r  <= {XW{1'b0}};
            bar_idx_r  <= 3'd0;
            cfg_mode_r <= MODE_SOLID;
            cfg_fg_r   <= 24'h000000;
            cfg_bg_r   <= 24'h000000;
            tdata_r    <= 32'h0000_0000;
            tlast_r    <= 1'b0;
            tuser_r    <= 1'b0;
        end else if (load_s) begin
            x_r       <= nx_s;
            y_r       <= ny_s;
            bar_cnt_r <= nbar_cnt_s;
            bar_idx_r <= nbar_idx_s;
            tdata_r   <= pack_tdata(lut_rgb_s);
            tlast_r   <= (nx_s == X_LAST);
            tuser_r   <= start_s;
            if (start_s) begin
                cfg_mode_r <= lut_mode_s;
                cfg_fg_r   <= fg_rgb;
                cfg_bg_r   <= bg_rgb;
            end
        end
    end

    assign out_stream_tdata  = tdata_r;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_r;
    assign out_stream_tuser  = tuser_r;
    assign out_stream_tvalid = tvalid_r;
    assign frame_count       = frame_count_r;
    assign busy              = busy_r;

endmodule
